// File: rtl/soc_mem_pkg.sv
// soc_mem_pkg: types and defaults shared by the SRAM arbiter and its owner pipe.
//   owner_e       - which requester a read-data beat belongs to
//   pipe_entry_t  - one owner-pipe stage {valid, owner, oob}
//   MEM_WORDS_DEF - implemented SRAM words (24 kB)
//   WB_BASE_DEF   - Wishbone byte base address of the SRAM window
//   sat_inc16     - saturating 16-bit increment used by the statistics counters
package soc_mem_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_WB   = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   oob;
  } pipe_entry_t;

  localparam int          MEM_WORDS_DEF = 6144;
  localparam logic [31:0] WB_BASE_DEF   = 32'h3000_0000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/mem_owner_pipe.sv
// mem_owner_pipe: DEPTH-deep shift register tracking who owns each in-flight
// SRAM read, so the returning sram_dout beat is routed to exactly one requester.
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset; flushes every stage
//   push_i  - entry for the access issued this cycle (valid only for reads)
//   head_o  - entry whose read data is on the SRAM output this cycle
module mem_owner_pipe
  import soc_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  pipe_entry_t push_i,
  output pipe_entry_t head_o
);

  pipe_entry_t stage_q [DEPTH];

  // NOTE: this array is reset because flushing in-flight reads is functional
  // behaviour; a plain data store would be left unreset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= push_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign head_o = stage_q[DEPTH-1];

endmodule

// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: shares the single-port main SRAM between the core data port
// (priority, pipelined, one access per cycle) and the management Wishbone slave
// (one transaction outstanding, starvation-protected).
// Ports:
//   clk_i, rst_ni              - clock, asynchronous active-low reset
//   core_*                     - core request, combinational grant, read return
//   wb_*                       - Wishbone B4 classic slave, single-cycle ack
//   sram_*                     - single-port SRAM macro (active-low csb/web)
//   stat_*_o                   - grant/conflict counters, only with ARB_STATS_EN
// Optional feature: define ARB_STATS_EN to add saturating 16-bit statistics.
module soc_mem_arbiter
  import soc_mem_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          SRAM_AW    = 13,
  parameter int          MEM_WORDS  = MEM_WORDS_DEF,
  parameter logic [31:0] WB_BASE    = WB_BASE_DEF,
  parameter int          RD_LAT     = 1,
  parameter int          STARVE_MAX = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                core_req_i,
  input  logic                core_we_i,
  input  logic [DATA_W/8-1:0] core_be_i,
  input  logic [31:0]         core_addr_i,
  input  logic [DATA_W-1:0]   core_wdata_i,
  output logic                core_gnt_o,
  output logic                core_rvalid_o,
  output logic [DATA_W-1:0]   core_rdata_o,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic                wb_ack_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                sram_csb_o,
  output logic                sram_web_o,
  output logic [DATA_W/8-1:0] sram_wmask_o,
  output logic [SRAM_AW-1:0]  sram_addr_o,
  output logic [DATA_W-1:0]   sram_din_o,
  input  logic [DATA_W-1:0]   sram_dout_i
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]         stat_core_o,
  output logic [15:0]         stat_wb_o,
  output logic [15:0]         stat_conflict_o
`endif
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

  logic             en_q;        // low during reset, so no grant can escape it
  logic             wb_busy_q;
  logic             wb_wack_q;
  logic [CNT_W-1:0] starve_q;

  logic wb_valid, wb_win, core_win;
  logic sel_we, sel_oob;
  pipe_entry_t push, head;

  // Address decode. Wishbone addresses below the base wrap to a huge index and
  // therefore also land out of range.
  logic [31:0]        wb_off, wb_widx;
  logic               wb_oob, core_oob;
  logic [SRAM_AW-1:0] core_word;
  logic               unused_addr;

  assign wb_off      = wb_adr_i - WB_BASE;
  assign wb_widx     = wb_off >> 2;
  assign wb_oob      = (wb_adr_i < WB_BASE) || (wb_widx >= 32'(MEM_WORDS));
  assign core_word   = core_addr_i[SRAM_AW+1:2];
  assign core_oob    = 32'(core_word) >= 32'(MEM_WORDS);
  assign unused_addr = ^{core_addr_i[31:SRAM_AW+2], core_addr_i[1:0]};

  // Arbitration. The ack cycle is excluded so a held stb is not serviced twice.
  assign wb_valid   = en_q & wb_cyc_i & wb_stb_i & ~wb_busy_q & ~wb_ack_o;
  assign wb_win     = wb_valid & (~core_req_i | (starve_q == STARVE_LIM));
  assign core_win   = en_q & core_req_i & ~wb_win;
  assign core_gnt_o = core_win;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
    sel_we       = 1'b0;
    sel_oob      = 1'b0;
    push         = '0;
    if (en_q) begin
      // Core fields stay on the bus when idle so nothing floats to X.
      if (wb_win) begin
        sram_addr_o  = wb_widx[SRAM_AW-1:0];
        sram_din_o   = wb_dat_i;
        sram_wmask_o = wb_sel_i;
        sel_we       = wb_we_i;
        sel_oob      = wb_oob;
      end else begin
        sram_addr_o  = core_word;
        sram_din_o   = core_wdata_i;
        sram_wmask_o = core_be_i;
        sel_we       = core_we_i;
        sel_oob      = core_oob;
      end
      if ((wb_win | core_win) & ~sel_oob) begin
        sram_csb_o = 1'b0;
        sram_web_o = ~sel_we;
      end
      push.valid = (wb_win | core_win) & ~sel_we;
      push.owner = wb_win ? OWN_WB : OWN_CORE;
      push.oob   = sel_oob;
    end
  end

  mem_owner_pipe #(.DEPTH(RD_LAT)) u_owner_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .head_o (head)
  );

  // Read return: out-of-range reads complete with zero data.
  logic              rd_core, rd_wb;
  logic [DATA_W-1:0] rd_data;

  assign rd_core       = head.valid & (head.owner == OWN_CORE);
  assign rd_wb         = head.valid & (head.owner == OWN_WB);
  assign rd_data       = head.oob ? '0 : sram_dout_i;
  assign core_rvalid_o = rd_core;
  assign core_rdata_o  = rd_core ? rd_data : '0;
  assign wb_ack_o      = wb_wack_q | rd_wb;
  assign wb_dat_o      = rd_wb ? rd_data : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q      <= 1'b0;
      wb_busy_q <= 1'b0;
      wb_wack_q <= 1'b0;
      starve_q  <= '0;
    end else begin
      en_q      <= 1'b1;
      wb_wack_q <= wb_win & wb_we_i;
      if (wb_win)        wb_busy_q <= 1'b1;
      else if (wb_ack_o) wb_busy_q <= 1'b0;
      if (wb_win | ~wb_stb_i)                     starve_q <= '0;
      else if (wb_valid && starve_q != STARVE_LIM) starve_q <= starve_q + 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_core_o     <= '0;
      stat_wb_o       <= '0;
      stat_conflict_o <= '0;
    end else begin
      if (core_win)               stat_core_o     <= sat_inc16(stat_core_o);
      if (wb_win)                 stat_wb_o       <= sat_inc16(stat_wb_o);
      if (core_req_i && wb_valid) stat_conflict_o <= sat_inc16(stat_conflict_o);
    end
  end
`endif

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// tb_soc_mem_arbiter: directed bench for soc_mem_arbiter with a behavioural
// SRAM, a reference memory and read-data scoreboards for both requesters.
module tb_soc_mem_arbiter;
  import soc_mem_pkg::*;

  localparam int RD_LAT = 1;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [3:0]  core_be_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic        core_gnt_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        sram_csb_o, sram_web_o;
  logic [3:0]  sram_wmask_o;
  logic [12:0] sram_addr_o;
  logic [31:0] sram_din_o, sram_dout_i;
`ifdef ARB_STATS_EN
  logic [15:0] stat_core_o, stat_wb_o, stat_conflict_o;
`endif

  always #5 clk_i = ~clk_i;

  soc_mem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
    .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o),
    .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i)
`ifdef ARB_STATS_EN
    , .stat_core_o(stat_core_o), .stat_wb_o(stat_wb_o), .stat_conflict_o(stat_conflict_o)
`endif
  );

  // Behavioural single-port SRAM with RD_LAT-cycle registered read data.
  logic [31:0] sram_mem [8192];
  logic [31:0] rd_pipe  [RD_LAT];
  always @(posedge clk_i) begin
    if (!sram_csb_o && !sram_web_o) begin
      for (int b = 0; b < 4; b++)
        if (sram_wmask_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_din_o[8*b +: 8];
    end
    if (!sram_csb_o && sram_web_o) rd_pipe[0] <= sram_mem[sram_addr_o];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign sram_dout_i = rd_pipe[RD_LAT-1];

  int n_checks = 0;
  int n_errors = 0;
  int ack_seen = 0;
  int exp_acks = 0;
  logic [31:0] core_q [$];
  logic [31:0] wb_q   [$];
  logic [31:0] ref_mem [int];

  always @(negedge clk_i) if (wb_ack_o === 1'b1) ack_seen <= ack_seen + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_write(input int word, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] cur;
    cur = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
    for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = d[8*b +: 8];
    ref_mem[word] = cur;
  endfunction

  function automatic logic [31:0] ref_read(input int word);
    return ref_mem.exists(word) ? ref_mem[word] : 32'h0;
  endfunction

  task automatic idle_inputs();
    core_req_i = 0; core_we_i = 0; core_be_i = 0; core_addr_i = 0; core_wdata_i = 0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 0; wb_adr_i = 0; wb_dat_i = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic pop_core(input string tag);
    check({tag, "_rvalid"}, core_rvalid_o, 1);
    if (core_q.size() == 0) begin
      n_checks++; n_errors++;
      $error("FAIL %s_scoreboard observed=rvalid expected=no pending read", tag);
    end else check({tag, "_rdata"}, core_rdata_o, core_q.pop_front());
  endtask

  task automatic pop_wb(input string tag);
    check({tag, "_ack"}, wb_ack_o, 1);
    if (wb_q.size() == 0) begin
      n_checks++; n_errors++;
      $error("FAIL %s_scoreboard observed=ack expected=no pending read", tag);
    end else check({tag, "_dat"}, wb_dat_o, wb_q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_csb"},    sram_csb_o,    1);
    check({tag, "_web"},    sram_web_o,    1);
    check({tag, "_gnt"},    core_gnt_o,    0);
    check({tag, "_rvalid"}, core_rvalid_o, 0);
    check({tag, "_rdata"},  core_rdata_o,  0);
    check({tag, "_ack"},    wb_ack_o,      0);
    check({tag, "_wbdat"},  wb_dat_o,      0);
    check({tag, "_wmask"},  sram_wmask_o,  0);
    check({tag, "_addr"},   sram_addr_o,   0);
    check({tag, "_din"},    sram_din_o,    0);
  endtask

  initial begin
    logic exp_gnt, prev_core, prev_wb;
    int word;

    // Reset, with requests asserted to show they cannot leak through.
    idle_inputs();
    rst_ni = 0;
    core_req_i = 1; wb_cyc_i = 1; wb_stb_i = 1; wb_adr_i = 32'h3000_0040;
    @(negedge clk_i); @(negedge clk_i);
    check_reset_outputs("reset");
    idle_inputs();
    rst_ni = 1;
    next_cycle();

    // Core write then read of 0x40; ack never asserts.
    core_req_i = 1; core_we_i = 1; core_be_i = 4'hF; core_addr_i = 32'h40;
    core_wdata_i = 32'h1234_5678;
    #1;
    check("cw_gnt", core_gnt_o, 1);
    check("cw_csb", sram_csb_o, 0);
    check("cw_web", sram_web_o, 0);
    check("cw_addr", sram_addr_o, 32'h10);
    check("cw_din", sram_din_o, 32'h1234_5678);
    check("cw_wmask", sram_wmask_o, 4'hF);
    ref_write(32'h10, 4'hF, 32'h1234_5678);
    next_cycle();
    check("cw_no_rvalid", core_rvalid_o, 0);
    core_we_i = 0; core_wdata_i = 32'hDEAD_BEEF;
    #1;
    check("cr_gnt", core_gnt_o, 1);
    check("cr_web", sram_web_o, 1);
    core_q.push_back(ref_read(32'h10));
    next_cycle();
    idle_inputs();
    pop_core("cr");
    check("cr_acks", ack_seen, exp_acks);

    // Wishbone read with the core idle; stb held through the ack cycle.
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_sel_i = 4'hF; wb_adr_i = 32'h3000_0040;
    #1;
    check("wbr_core_gnt", core_gnt_o, 0);
    check("wbr_csb", sram_csb_o, 0);
    check("wbr_addr", sram_addr_o, 32'h10);
    check("wbr_ack_early", wb_ack_o, 0);
    wb_q.push_back(ref_read(32'h10));
    exp_acks++;
    next_cycle();
    pop_wb("wbr");
    check("wbr_no_regrant", sram_csb_o, 1);
    wb_cyc_i = 0; wb_stb_i = 0;
    next_cycle();
    check("wbr_ack_once", ack_seen, exp_acks);

    // Starvation: core reads every cycle, Wishbone wins once after STARVE_MAX losses.
    core_req_i = 1; core_we_i = 0; core_be_i = 4'hF; core_addr_i = 32'h40;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_sel_i = 4'hF; wb_adr_i = 32'h3000_0040;
    prev_core = 0; prev_wb = 0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        if (prev_wb) begin
          pop_wb($sformatf("starve_wb[%0d]", i));
          wb_cyc_i = 0; wb_stb_i = 0;
        end else check($sformatf("starve_noack[%0d]", i), wb_ack_o, 0);
        if (prev_core) pop_core($sformatf("starve_core[%0d]", i));
        else check($sformatf("starve_norv[%0d]", i), core_rvalid_o, 0);
      end
      #1;
      exp_gnt = (i != 8);
      check($sformatf("starve_gnt[%0d]", i), core_gnt_o, exp_gnt);
      check($sformatf("starve_csb[%0d]", i), sram_csb_o, 0);
      if (exp_gnt) core_q.push_back(ref_read(32'h10));
      else begin wb_q.push_back(ref_read(32'h10)); exp_acks++; end
      prev_core = exp_gnt; prev_wb = !exp_gnt;
      next_cycle();
    end
    pop_core("starve_last");
    idle_inputs();
    next_cycle();

    // Byte-masked Wishbone write, then core read-back.
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_sel_i = 4'b0010;
    wb_adr_i = 32'h3000_0040; wb_dat_i = 32'hAABB_CCDD;
    #1;
    check("wbw_csb", sram_csb_o, 0);
    check("wbw_web", sram_web_o, 0);
    check("wbw_wmask", sram_wmask_o, 4'b0010);
    check("wbw_din", sram_din_o, 32'hAABB_CCDD);
    ref_write(32'h10, 4'b0010, 32'hAABB_CCDD);
    exp_acks++;
    next_cycle();
    check("wbw_ack", wb_ack_o, 1);
    idle_inputs();
    next_cycle();
    core_req_i = 1; core_addr_i = 32'h40; core_be_i = 4'hF;
    #1;
    check("mask_gnt", core_gnt_o, 1);
    core_q.push_back(ref_read(32'h10));
    next_cycle();
    idle_inputs();
    pop_core("mask");
    check("mask_value", ref_read(32'h10), 32'h1234_CC78);

    // Out of range: Wishbone read past the window, below the base, core word 6144.
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_sel_i = 4'hF; wb_adr_i = 32'h3000_6000;
    #1;
    check("oob_wb_csb", sram_csb_o, 1);
    wb_q.push_back(32'h0);
    exp_acks++;
    next_cycle();
    pop_wb("oob_wb");
    idle_inputs();
    next_cycle();
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_sel_i = 4'hF;
    wb_adr_i = 32'h2FFF_FFF0; wb_dat_i = 32'h5555_5555;
    #1;
    check("oob_low_csb", sram_csb_o, 1);
    exp_acks++;
    next_cycle();
    check("oob_low_ack", wb_ack_o, 1);
    idle_inputs();
    next_cycle();
    word = 6144;
    core_req_i = 1; core_we_i = 0; core_be_i = 4'hF; core_addr_i = 32'(word) << 2;
    #1;
    check("oob_core_gnt", core_gnt_o, 1);
    check("oob_core_csb", sram_csb_o, 1);
    core_q.push_back(32'h0);
    next_cycle();
    idle_inputs();
    pop_core("oob_core");
    check("oob_acks", ack_seen, exp_acks);

    // Reset asserted in the cycle after a core read grant.
    core_req_i = 1; core_addr_i = 32'h40; core_be_i = 4'hF;
    #1;
    check("rst_rd_gnt", core_gnt_o, 1);
    @(posedge clk_i);
    #1;
    rst_ni = 0;
    wb_cyc_i = 1; wb_stb_i = 1; wb_adr_i = 32'h3000_0040;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk_i);
    idle_inputs();
    rst_ni = 1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check($sformatf("rst_after_rv[%0d]", i), core_rvalid_o, 0);
      check($sformatf("rst_after_ack[%0d]", i), wb_ack_o, 0);
    end
    check("final_acks", ack_seen, exp_acks);
    check("final_core_q", core_q.size(), 0);
    check("final_wb_q", wb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
